// File: rtl/aes_pkg.sv
// Shared AES definitions for the encryption datapath stages.
package aes_pkg;

  localparam int AES_W = 128;
  localparam int NR = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Row-major table: entry 0 sits in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry a starts at bit 8*(255-a); 255-a is simply ~a.
  logic [10:0] bit_idx;
  assign bit_idx = {~a, 3'b000};

  // Table lookup.
  assign y = SBOX_TABLE[bit_idx +: 8];

endmodule

// File: rtl/add_round_key.sv
// AES-128 round-key stage: XORs each accepted state with the current round
// key and expands the key schedule on the fly, one round key per accept.
//
// Handshake: an input transfer happens on a rising edge where i_Valid and
// o_Ready are both high; an output transfer happens where o_Valid and i_Ready
// are both high. o_Valid/o_Data/o_Round/o_Last are registered and hold until
// their transfer; a new accept in the drain cycle replaces the old result.
module add_round_key #(
  parameter int NR = aes_pkg::NR
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_Key_Load,
  input  logic [127:0]         i_Key,
  input  logic                 i_Valid,
  input  logic [127:0]         i_Data,
  output logic                 o_Ready,
  output logic                 o_Valid,
  input  logic                 i_Ready,
  output logic [127:0]         o_Data,
  output logic [3:0]           o_Round,
  output logic                 o_Last,
  output aes_pkg::state_t      o_Dbg_State
);

  import aes_pkg::*;

  localparam logic [3:0] LAST_RND = 4'(NR);

  state_t       state;
  logic [127:0] key_reg;
  logic [3:0]   rnd;
  logic [7:0]   rcon;

  logic         accept;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w3;
  logic [31:0]  sub_w3;
  logic [31:0]  t_word;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_key;
  logic [127:0] round_key;

  // Accept only while rounds remain, no reload is in progress and the output
  // register is free or being drained this cycle.
  assign o_Ready = (state == RUN) && !i_Key_Load && (!o_Valid || i_Ready);
  assign accept  = i_Valid && o_Ready;

  assign o_Dbg_State = state;

  // Key schedule step: words of the current key, w0 is the most significant.
  assign w0     = key_reg[127:96];
  assign w1     = key_reg[95:64];
  assign w2     = key_reg[63:32];
  assign w3     = key_reg[31:0];
  assign rot_w3 = {w3[23:0], w3[31:24]};

  // SubWord on the rotated last word, one S-box per byte.
  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .a (rot_w3[8*g +: 8]),
      .y (sub_w3[8*g +: 8])
    );
  end

  assign t_word   = sub_w3 ^ {rcon, 24'h000000};
  assign n0       = w0 ^ t_word;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  // Round 0 uses the cipher key itself; later rounds use the expanded key.
  assign round_key = (rnd == 4'd0) ? key_reg : next_key;

  // Control FSM, key schedule registers and registered output stage.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state   <= IDLE;
      key_reg <= '0;
      rnd     <= 4'd0;
      rcon    <= RCON_INIT;
      o_Valid <= 1'b0;
      o_Data  <= '0;
      o_Round <= 4'd0;
      o_Last  <= 1'b0;
    end else if (i_Key_Load) begin
      state   <= RUN;
      key_reg <= i_Key;
      rnd     <= 4'd0;
      rcon    <= RCON_INIT;
      o_Valid <= 1'b0;
    end else begin
      if (o_Valid && i_Ready) begin
        o_Valid <= 1'b0;
      end
      if (accept) begin
        o_Valid <= 1'b1;
        o_Data  <= i_Data ^ round_key;
        o_Round <= rnd;
        o_Last  <= (rnd == LAST_RND);
        if (rnd != 4'd0) begin
          key_reg <= next_key;
          rcon    <= xtime(rcon);
        end
        if (rnd == LAST_RND) begin
          state <= DONE;
        end else begin
          rnd <= rnd + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_add_round_key.sv
// Bench for add_round_key: directed FIPS-197 vectors plus a small AES model
// that supplies the per-round inputs and expected round outputs.
module tb_add_round_key;

  import aes_pkg::*;

  typedef logic [132:0] exp_t;  // {last, round, data}

  typedef struct {
    logic [127:0] data;
    logic [127:0] exp_data;
    logic [3:0]   rnd;
    logic         last;
  } vec_t;

  logic         clk = 1'b0;
  logic         i_Rst = 1'b1;
  logic         i_Key_Load = 1'b0;
  logic [127:0] i_Key = '0;
  logic         i_Valid = 1'b0;
  logic [127:0] i_Data = '0;
  logic         i_Ready = 1'b1;
  logic         o_Ready;
  logic         o_Valid;
  logic [127:0] o_Data;
  logic [3:0]   o_Round;
  logic         o_Last;
  state_t       o_Dbg_State;

  exp_t         exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  logic [7:0]   sbox_tab [256];
  logic [127:0] mk;
  logic [7:0]   mrcon;
  logic [3:0]   mrnd;

  // Clock.
  always #5 clk = ~clk;

  add_round_key #(.NR(10)) dut (
    .i_Clk       (clk),
    .i_Rst       (i_Rst),
    .i_Key_Load  (i_Key_Load),
    .i_Key       (i_Key),
    .i_Valid     (i_Valid),
    .i_Data      (i_Data),
    .o_Ready     (o_Ready),
    .o_Valid     (o_Valid),
    .i_Ready     (i_Ready),
    .o_Data      (o_Data),
    .o_Round     (o_Round),
    .o_Last      (o_Last),
    .o_Dbg_State (o_Dbg_State)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] tb_xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] tb_subword(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  function automatic logic [127:0] tb_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, a0, a1, a2, a3;
    t  = tb_subword({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    a0 = k[127:96] ^ t;
    a1 = k[95:64] ^ a0;
    a2 = k[63:32] ^ a1;
    a3 = k[31:0] ^ a2;
    return {a0, a1, a2, a3};
  endfunction

  function automatic logic [127:0] tb_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox_tab[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] tb_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] tb_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = tb_xt(a0) ^ tb_xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ tb_xt(a1) ^ tb_xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ tb_xt(a2) ^ tb_xt(a3) ^ a3;
      o[103-32*c -: 8] = tb_xt(a0) ^ a0 ^ a1 ^ a2 ^ tb_xt(a3);
    end
    return o;
  endfunction

  task automatic model_reset(input logic [127:0] k);
    mk    = k;
    mrcon = 8'h01;
    mrnd  = 4'd0;
  endtask

  task automatic model_step(input logic [127:0] d, output exp_t e);
    if (mrnd != 4'd0) begin
      mk    = tb_expand(mk, mrcon);
      mrcon = tb_xt(mrcon);
    end
    e    = {(mrnd == 4'd10), mrnd, d ^ mk};
    mrnd = mrnd + 4'd1;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [132:0] act, input logic [132:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Move to the sampling edge and retire any output transferred this cycle.
  task automatic to_neg();
    exp_t got;
    @(negedge clk);
    if (o_Valid && i_Ready) begin
      got = {o_Last, o_Round, o_Data};
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got %h, expected none", got);
      end else begin
        chk("scoreboard", got, exp_q.pop_front());
      end
    end
  endtask

  // Move just past the active edge, where inputs are driven.
  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic issue(input logic [127:0] d, input exp_t e);
    bit done;
    done    = 1'b0;
    i_Valid = 1'b1;
    i_Data  = d;
    for (int i = 0; i < 20 && !done; i++) begin
      to_neg();
      if (o_Ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
      to_pos();
    end
    i_Valid = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: got o_Ready=0 for 20 cycles, expected an accept");
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    i_Key_Load = 1'b1;
    i_Key      = k;
    to_neg();
    to_pos();
    i_Key_Load = 1'b0;
    model_reset(k);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [2047:0] sb_bits;
    vec_t          sched [11];
    logic [127:0]  s, din, d4;
    exp_t          e, e3;

    sb_bits = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    for (int i = 0; i < 256; i++) sbox_tab[i] = sb_bits[2047-8*i -: 8];

    // Round 0 on the FIPS-197 example, then all-zero data exposes each round key.
    sched[0]  = '{128'h3243f6a8885a308d313198a2e0370734, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 4'd0, 1'b0};
    sched[1]  = '{128'h0, 128'ha0fafe1788542cb123a339392a6c7605, 4'd1, 1'b0};
    sched[2]  = '{128'h0, 128'hf2c295f27a96b9435935807a7359f67f, 4'd2, 1'b0};
    sched[3]  = '{128'h0, 128'h3d80477d4716fe3e1e237e446d7a883b, 4'd3, 1'b0};
    sched[4]  = '{128'h0, 128'hef44a541a8525b7fb671253bdb0bad00, 4'd4, 1'b0};
    sched[5]  = '{128'h0, 128'hd4d1c6f87c839d87caf2b8bc11f915bc, 4'd5, 1'b0};
    sched[6]  = '{128'h0, 128'h6d88a37a110b3efddbf98641ca0093fd, 4'd6, 1'b0};
    sched[7]  = '{128'h0, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f, 4'd7, 1'b0};
    sched[8]  = '{128'h0, 128'head27321b58dbad2312bf5607f8d292f, 4'd8, 1'b0};
    sched[9]  = '{128'h0, 128'hac7766f319fadc2128d12941575c006e, 4'd9, 1'b0};
    sched[10] = '{128'h0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 4'd10, 1'b1};

    // Reset held for two cycles.
    to_pos();
    to_pos();
    to_neg();
    chk("reset_valid", o_Valid, 1'b0);
    chk("reset_ready", o_Ready, 1'b0);
    chk("reset_data", o_Data, 128'h0);
    chk("reset_round_last", {o_Round, o_Last}, 5'h0);
    chk("reset_state", o_Dbg_State, IDLE);
    to_pos();
    i_Rst = 1'b0;

    // Valid pulses while idle must be ignored.
    i_Valid = 1'b1;
    i_Data  = rand128();
    for (int i = 0; i < 3; i++) begin
      to_neg();
      chk("idle_ready", o_Ready, 1'b0);
      chk("idle_valid", o_Valid, 1'b0);
      to_pos();
    end
    i_Valid = 1'b0;

    // Round 0 and the full key schedule, back to back.
    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    for (int i = 0; i < 11; i++)
      issue(sched[i].data, {sched[i].last, sched[i].rnd, sched[i].exp_data});
    to_neg();
    chk("done_ready", o_Ready, 1'b0);
    chk("done_state", o_Dbg_State, DONE);
    to_pos();

    // Further valid input after the last round is ignored.
    i_Valid = 1'b1;
    i_Data  = rand128();
    for (int i = 0; i < 2; i++) begin
      to_neg();
      chk("done_no_accept", o_Ready, 1'b0);
      to_pos();
    end
    i_Valid = 1'b0;

    // Full encryption: the model supplies the SubBytes/ShiftRows/MixColumns inputs.
    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    s = 128'h3243f6a8885a308d313198a2e0370734;
    for (int r = 0; r <= 10; r++) begin
      if (r == 0) din = s;
      else if (r < 10) din = tb_mix_columns(tb_shift_rows(tb_sub_bytes(s)));
      else din = tb_shift_rows(tb_sub_bytes(s));
      model_step(din, e);
      if (r == 10) e = {1'b1, 4'd10, 128'h3925841d02dc09fbdc118597196a0b32};
      s = e[127:0];
      issue(din, e);
    end

    // Backpressure at round 3, with round 4 waiting on the input.
    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    for (int r = 0; r < 3; r++) begin
      din = rand128();
      model_step(din, e);
      issue(din, e);
    end
    din = rand128();
    model_step(din, e3);
    issue(din, e3);
    i_Ready = 1'b0;
    d4      = rand128();
    i_Valid = 1'b1;
    i_Data  = d4;
    for (int i = 0; i < 5; i++) begin
      to_neg();
      chk("stall_valid", o_Valid, 1'b1);
      chk("stall_data", o_Data, e3[127:0]);
      chk("stall_round", o_Round, 4'd3);
      chk("stall_ready", o_Ready, 1'b0);
      to_pos();
    end
    i_Ready = 1'b1;
    to_neg();
    chk("release_ready", o_Ready, 1'b1);
    model_step(d4, e);
    exp_q.push_back(e);
    to_pos();
    i_Valid = 1'b0;

    // Key reload at round 5 with valid input in the same cycle.
    i_Key_Load = 1'b1;
    i_Key      = 128'h000102030405060708090a0b0c0d0e0f;
    i_Valid    = 1'b1;
    i_Data     = rand128();
    to_neg();
    chk("reload_ready", o_Ready, 1'b0);
    to_pos();
    i_Key_Load = 1'b0;
    i_Valid    = 1'b0;
    to_neg();
    chk("reload_valid", o_Valid, 1'b0);
    chk("reload_state", o_Dbg_State, RUN);
    to_pos();
    model_reset(128'h000102030405060708090a0b0c0d0e0f);
    issue(128'h00112233445566778899aabbccddeeff, {1'b0, 4'd0, 128'h00102030405060708090a0b0c0d0e0f0});
    issue(128'h0, {1'b0, 4'd1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe});

    // Reset in the middle of a run.
    i_Rst = 1'b1;
    to_neg();
    to_pos();
    i_Rst = 1'b0;
    to_neg();
    chk("midreset_valid", o_Valid, 1'b0);
    chk("midreset_data", o_Data, 128'h0);
    chk("midreset_ready", o_Ready, 1'b0);
    chk("midreset_state", o_Dbg_State, IDLE);
    to_pos();

    // Everything expected must have come out.
    for (int i = 0; i < 3; i++) begin
      to_neg();
      to_pos();
    end
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/add_round_key.md
# add_round_key

Round-key stage of the iterative AES-128 encryption datapath. It sits directly downstream of the MixColumns stage and consumes its 128-bit output. It XORs each incoming state with the current round key and expands the key schedule on the fly, one round key per accepted state. Results are presented on a registered valid/ready output.

## Interface
Parameters:
- NR, 10, number of AES rounds. Fixed for AES-128.

Ports:
- i_Clk  input  1  clock; the block has one clock domain.
- i_Rst  input  1  reset; synchronous, active-high.
- i_Key_Load  input  1  load i_Key and restart the schedule at round 0.
- i_Key  input  128  cipher key; bits [127:120] are byte 0.
- i_Valid  input  1  i_Data is valid.
- i_Data  input  128  state to be keyed:
  - plaintext for round 0;
  - MixColumns output for rounds 1..9;
  - ShiftRows output for round 10 (the caller muxes the source).
- o_Ready  output  1  block accepts i_Data this cycle.
- o_Valid  output  1  o_Data holds a result.
- i_Ready  input  1  downstream accepts o_Data.
- o_Data  output  128  keyed state.
- o_Round  output  4  round index (0..10) of o_Data.
- o_Last  output  1  o_Data is round NR, i.e. the ciphertext.

## Operation
- State machine:
  - IDLE: no key loaded.
  - RUN: rounds 0..NR pending.
  - DONE: round NR accepted; waiting for a new key.
- Key register K (128 bits), round counter rnd (4 bits), rcon register (8 bits).
- i_Key_Load, in any state:
  - K <= i_Key, rnd <= 0, rcon <= 8'h01;
  - state -> RUN; o_Valid <= 0 (a pending result is discarded).
  - i_Valid in the same cycle is ignored.
- o_Ready = (state == RUN) && !i_Key_Load && (!o_Valid || i_Ready).
- Accept means i_Valid && o_Ready.
- Accept with rnd == 0:
  - o_Data <= i_Data ^ K; K is unchanged.
- Accept with rnd in 1..NR:
  - NK = expand(K, rcon); o_Data <= i_Data ^ NK.
  - K <= NK; rcon <= xtime(rcon), where xtime(x) = {x[6:0],0} ^ (x[7] ? 8'h1b : 0).
- Every accept sets o_Round <= rnd and o_Last <= (rnd == NR).
  - If rnd == NR: state -> DONE. Otherwise rnd <= rnd + 1.
- expand(K, rcon), with words w0 = K[127:96] .. w3 = K[31:0]:
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}, where RotWord({a,b,c,d}) = {b,c,d,a}.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - NK = {n0,n1,n2,n3}.
- In IDLE and DONE: o_Ready = 0; i_Valid is ignored.

## Timing
- Reset values: state IDLE, o_Valid 0, o_Data 0, o_Round 0, o_Last 0, K 0, rcon 8'h01, rnd 0. Consequently o_Ready is 0.
- Latency: 1 cycle from accept to o_Valid. Key expansion is completed in the same cycle, so there is no extra latency.
- Throughput: 1 state per cycle while i_Ready stays high.
- Output hold: o_Valid, o_Data, o_Round and o_Last stay stable until the cycle where o_Valid && i_Ready.
- Simultaneous output drain and new accept: the new result replaces the old one; o_Valid stays 1.
- Backpressure: with o_Valid=1 and i_Ready=0, o_Ready=0, and K, rnd and rcon are frozen.
- Reset mid-operation: everything returns to reset values on the next edge; the key must be reloaded.
- rcon sequence across rounds 1..10: 01,02,04,08,10,20,40,80,1b,36. No wrap occurs, because DONE blocks any further accept.

## Structure
- Shared package aes_pkg holds:
  - AES_W = 128 and NR = 10;
  - RCON_INIT = 8'h01;
  - the state enum {IDLE, RUN, DONE};
  - the xtime function, shared with the MixColumns stage.
- Sub-module aes_sbox: combinational 8-bit forward S-box, shared with the SubBytes stage. The key-expansion SubWord uses 4 instances.

## Test plan
- Reset: assert i_Rst for 2 cycles -> o_Valid=0, o_Ready=0, o_Data=0; i_Valid pulses during IDLE produce no output.
- Round 0: load key 2b7e151628aed2a6abf7158809cf4f3c, then send i_Data 3243f6a8885a308d313198a2e0370734 -> next cycle o_Data=193de3bea0f4e22b9ac68d2ae9f84808, o_Round=0, o_Last=0.
- Schedule check: send all-zero i_Data for rounds 1..10 with i_Ready=1:
  - round 1 -> o_Data=a0fafe1788542cb123a339392a6c7605;
  - round 10 -> o_Data=d014f9a8c9ee2589e13f0cc8b6630ca6, o_Last=1;
  - afterwards o_Ready=0 (DONE).
- Full encryption: a reference model supplies the MixColumns/ShiftRows inputs -> round 10 o_Data=3925841d02dc09fbdc118597196a0b32.
- Backpressure: hold i_Ready=0 for 5 cycles at round 3 -> o_Data and o_Round stay stable, o_Ready=0, K unchanged. On release the round 4 result matches the model.
- Key reload mid-run: assert i_Key_Load at round 5 with i_Valid=1 -> input ignored, o_Valid=0 next cycle, the next accept is round 0 under the new key.
